// File: rtl/mont_mult_arbiter.sv
// mont_mult_arbiter: round-robin sharing of one bit-serial
// Montgomery multiplier among NREQ field-arithmetic requesters.
//
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   req[NREQ]            request levels, held until own gnt bit
//   opa/opb[NREQ*SIZE]   operands, requester k at [k*SIZE +: SIZE]
//   gnt[NREQ]            one-hot pulse: operands captured
//   rsp_valid[NREQ]      one-hot pulse: result on rsp_data
//   rsp_data[SIZE]       product (0 on timeout)
//   rsp_err              response is a timeout abort
//   busy                 high outside IDLE
//   err_timeout          sticky timeout flag
//   mult_start           start pulse to the multiplier
//   mult_in_0/1[SIZE]    registered multiplier operands
//   mult_out[SIZE]       multiplier result
//   mult_done            multiplier done pulse
module mont_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 63
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] opa,
  input  logic [NREQ*SIZE-1:0] opb,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [SIZE-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 mult_start,
  output logic [SIZE-1:0]      mult_in_0,
  output logic [SIZE-1:0]      mult_in_1,
  input  logic [SIZE-1:0]      mult_out,
  input  logic                 mult_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   owner_d;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [SIZE-1:0] rsp_data_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic            err_to_q;
  logic            start_q;
  logic [SIZE-1:0] in0_q;
  logic [SIZE-1:0] in1_q;
  logic            found;
  int              k;

  // Search begins one past the last owner, so the
  // requester just served ends up with lowest priority.
  always_comb begin
    owner_d = last_q;
    found   = 1'b0;
    k       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last_q) + i) % NREQ;
      if (!found && req[k[IW-1:0]]) begin
        found   = 1'b1;
        owner_d = k[IW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      last_q      <= IW'(NREQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
      start_q     <= 1'b0;
      in0_q       <= '0;
      in1_q       <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            owner_q <= owner_d;
            in0_q   <= opa[int'(owner_d)*SIZE +: SIZE];
            in1_q   <= opb[int'(owner_d)*SIZE +: SIZE];
            gnt_q   <= ONE << owner_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done wins over a same-cycle timeout
          if (mult_done) begin
            rsp_data_q  <= mult_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= ONE << owner_q;
            state_q     <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            err_to_q    <= 1'b1;
            rsp_valid_q <= ONE << owner_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign err_timeout = err_to_q;
  assign mult_start  = start_q;
  assign mult_in_0   = in0_q;
  assign mult_in_1   = in1_q;

endmodule

// File: tb/tb_mont_mult_arbiter.sv
// tb_mont_mult_arbiter: self-checking bench with a
// behavioural multiplier and round-robin reference model.
module tb_mont_mult_arbiter;
  localparam int NREQ = 4;
  localparam int SIZE = 32;
  localparam int TIMEOUT = 63;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*SIZE-1:0] opa = '0;
  logic [NREQ*SIZE-1:0] opb = '0;
  logic [NREQ-1:0] gnt, rsp_valid;
  logic [SIZE-1:0] rsp_data, mult_in_0, mult_in_1;
  logic rsp_err, busy, err_timeout, mult_start;
  logic [SIZE-1:0] mult_out;
  logic mult_done, model_done;
  logic force_done = 1'b0;

  assign mult_done = model_done | force_done;

  always #5 i_clk = ~i_clk;

  mont_mult_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .req(req),
    .opa(opa), .opb(opb), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .err_timeout(err_timeout), .mult_start(mult_start),
    .mult_in_0(mult_in_0), .mult_in_1(mult_in_1),
    .mult_out(mult_out), .mult_done(mult_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_last = NREQ - 1;

  // multiplier model: done mlat cycles after start
  int mlat = 36;
  bit mdl_en = 1'b1;
  bit mfix = 1'b0;
  logic [SIZE-1:0] mfix_val = '0;
  int mcnt;
  logic [SIZE-1:0] ma, mb;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      model_done <= 1'b0;
      mcnt <= 0;
      mult_out <= '0;
    end else begin
      model_done <= 1'b0;
      if (mult_start) begin
        mcnt <= mlat;
        ma <= mult_in_0;
        mb <= mult_in_1;
      end else if (mcnt == 1) begin
        mcnt <= 0;
        if (mdl_en) begin
          model_done <= 1'b1;
          mult_out <= mfix ? mfix_val : ma * mb;
        end
      end else if (mcnt > 1) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      n_cmp++;
      if ((|gnt && |rsp_valid) || !$onehot0(gnt)
          || !$onehot0(rsp_valid)) begin
        n_bad++;
        $display("FAIL onehot_excl gnt=%b rsp_valid=%b want onehot0, not both",
                 gnt, rsp_valid);
      end
    end
  end

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [SIZE-1:0] sl(input logic [NREQ*SIZE-1:0] v, input int w);
    return v[w*SIZE +: SIZE];
  endfunction

  function automatic logic [SIZE-1:0] prod(input int w);
    logic [SIZE-1:0] a, b, p;
    a = sl(opa, w);
    b = sl(opb, w);
    p = a * b;
    return p;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input int max, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < max) begin
      step();
      cyc++;
      ok = (sel == 0) ? |gnt : |rsp_valid;
    end
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    force_done = 1'b0;
    req = '0;
    step();
    step();
    i_rst = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic rand_ops();
    for (int j = 0; j < NREQ; j++) begin
      opa[j*SIZE +: SIZE] = $urandom;
      opb[j*SIZE +: SIZE] = $urandom;
    end
  endtask

  // observations of the last run_txn
  bit o_okg, o_okr;
  int o_gc, o_rc;
  logic [NREQ-1:0] o_gnt, o_rv, o_rv2;
  logic [SIZE-1:0] o_in0, o_in1, o_rd;
  logic o_ms, o_re, o_busy;

  task automatic run_txn(input logic [NREQ-1:0] r);
    req = r;
    wait_for(0, 20, o_gc, o_okg);
    o_gnt = gnt;
    o_ms = mult_start;
    o_in0 = mult_in_0;
    o_in1 = mult_in_1;
    req = req & ~gnt;
    o_okr = 1'b0;
    if (o_okg) begin
      wait_for(1, TIMEOUT + 20, o_rc, o_okr);
      o_rv = rsp_valid;
      o_rd = rsp_data;
      o_re = rsp_err;
      step();
      o_busy = busy;
      o_rv2 = rsp_valid;
    end
  endtask

  task automatic test_reset();
    step();
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data, rsp_err, busy, err_timeout,
         mult_start, mult_in_0, mult_in_1} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs gnt=%b rv=%b data=%h err=%b busy=%b to=%b st=%b want all 0",
               gnt, rsp_valid, rsp_data, rsp_err, busy, err_timeout, mult_start);
    end
    apply_reset();
  endtask

  task automatic test_single();
    rand_ops();
    opa[SIZE-1:0] = 32'h3;
    opb[SIZE-1:0] = 32'h5;
    mfix = 1'b1;
    mfix_val = 32'h12345678;
    run_txn(4'b0001);
    mfix = 1'b0;
    n_cmp++;
    if (!o_okg || o_gc != 1 || o_gnt !== 4'b0001 || o_ms !== 1'b1) begin
      n_bad++;
      $display("FAIL single_gnt ok=%0d cyc=%0d gnt=%b start=%b want cyc 1 gnt 0001 start 1",
               o_okg, o_gc, o_gnt, o_ms);
    end
    n_cmp++;
    if (o_in0 !== 32'h3 || o_in1 !== 32'h5) begin
      n_bad++;
      $display("FAIL single_ops in0=%h in1=%h want 3 5", o_in0, o_in1);
    end
    n_cmp++;
    if (!o_okr || o_rc + 1 != 39 || o_rv !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_rsp ok=%0d cyc=%0d rv=%b want cyc 39 rv 0001",
               o_okr, o_rc + 1, o_rv);
    end
    n_cmp++;
    if (o_rd !== 32'h12345678 || o_re !== 1'b0) begin
      n_bad++;
      $display("FAIL single_data data=%h err=%b want 12345678 0", o_rd, o_re);
    end
    n_cmp++;
    if (o_busy !== 1'b0 || o_rv2 !== '0) begin
      n_bad++;
      $display("FAIL single_idle busy=%b rv=%b want 0 0", o_busy, o_rv2);
    end
    m_last = 0;
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      rand_ops();
      w = pick(4'b1111, m_last);
      run_txn(4'b1111);
      n_cmp++;
      if (!o_okg || o_gnt !== (4'b0001 << w)) begin
        n_bad++;
        $display("FAIL rr_gnt t=%0d gnt=%b want %b", t, o_gnt, 4'b0001 << w);
      end
      n_cmp++;
      if (!o_okr || o_rv !== o_gnt || o_rd !== prod(w) || o_re !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_rsp t=%0d rv=%b data=%h err=%b want %b %h 0",
                 t, o_rv, o_rd, o_re, o_gnt, prod(w));
      end
      m_last = w;
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] seq [3];
    logic [NREQ-1:0] want [3];
    seq[0] = 4'b0100; want[0] = 4'b0100;
    seq[1] = 4'b0101; want[1] = 4'b0001;
    seq[2] = 4'b0100; want[2] = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      rand_ops();
      run_txn(seq[t]);
      n_cmp++;
      if (!o_okg || !o_okr || o_gnt !== want[t] || o_rv !== want[t]) begin
        n_bad++;
        $display("FAIL fair t=%0d gnt=%b rv=%b want %b", t, o_gnt, o_rv, want[t]);
      end
    end
    m_last = 2;
  endtask

  task automatic test_timeout();
    bit seen;
    rand_ops();
    mdl_en = 1'b0;
    run_txn(4'b0010);
    n_cmp++;
    if (!o_okg || !o_okr || o_rc != TIMEOUT + 1 || o_rv !== 4'b0010) begin
      n_bad++;
      $display("FAIL timeout_rsp ok=%0d/%0d dist=%0d rv=%b want 64 0010",
               o_okg, o_okr, o_rc, o_rv);
    end
    n_cmp++;
    if (o_re !== 1'b1 || o_rd !== '0 || err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err err=%b data=%h sticky=%b want 1 0 1",
               o_re, o_rd, err_timeout);
    end
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (|rsp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL late_done seen=%b sticky=%b busy=%b want 0 1 0",
               seen, err_timeout, busy);
    end
    mdl_en = 1'b1;
    m_last = 1;
  endtask

  task automatic test_spurious();
    bit seen, ok;
    int c;
    rand_ops();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (|rsp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_done seen=%b busy=%b want 0 0", seen, busy);
    end
    req = 4'b0001;
    wait_for(0, 20, c, ok);
    req = '0;
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    wait_for(1, TIMEOUT + 20, c, ok);
    n_cmp++;
    if (!ok || c != 37 || rsp_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL issue_done ok=%0d dist=%0d rv=%b want 37 0001", ok, c, rsp_valid);
    end
    n_cmp++;
    if (rsp_data !== prod(0) || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL issue_data data=%h err=%b want %h 0", rsp_data, rsp_err, prod(0));
    end
    step();
    m_last = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    rand_ops();
    req = 4'b0100;
    wait_for(0, 20, c, ok);
    req = '0;
    for (int i = 0; i < 19; i++) step();
    #3;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data, rsp_err, busy, err_timeout,
         mult_start, mult_in_0, mult_in_1} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset busy=%b to=%b in0=%h data=%h want all 0",
               busy, err_timeout, mult_in_0, rsp_data);
    end
    step();
    step();
    i_rst = 1'b0;
    m_last = NREQ - 1;
    rand_ops();
    run_txn(4'b0001);
    n_cmp++;
    if (!o_okg || o_gc != 1 || o_gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL post_reset_gnt cyc=%0d gnt=%b want 1 0001", o_gc, o_gnt);
    end
    n_cmp++;
    if (!o_okr || o_rc + 1 != 39 || o_rd !== prod(0) || o_rv !== 4'b0001) begin
      n_bad++;
      $display("FAIL post_reset_rsp cyc=%0d rv=%b data=%h want 39 0001 %h",
               o_rc + 1, o_rv, o_rd, prod(0));
    end
    m_last = 0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    int w;
    pend = '0;
    for (int t = 0; t < 24; t++) begin
      mlat = $urandom_range(1, 40);
      pend = pend | NREQ'($urandom_range(0, 15));
      if (pend == '0) pend = 4'b0001 << $urandom_range(0, 3);
      rand_ops();
      w = pick(pend, m_last);
      run_txn(pend);
      pend = req;
      n_cmp++;
      if (!o_okg || o_gnt !== (4'b0001 << w)) begin
        n_bad++;
        $display("FAIL rnd_gnt t=%0d gnt=%b want %b", t, o_gnt, 4'b0001 << w);
      end
      n_cmp++;
      if (o_in0 !== sl(opa, w) || o_in1 !== sl(opb, w)) begin
        n_bad++;
        $display("FAIL rnd_ops t=%0d in0=%h in1=%h want %h %h",
                 t, o_in0, o_in1, sl(opa, w), sl(opb, w));
      end
      n_cmp++;
      if (!o_okr || o_rc != mlat + 2 || o_rv !== o_gnt) begin
        n_bad++;
        $display("FAIL rnd_lat t=%0d dist=%0d rv=%b want %0d %b",
                 t, o_rc, o_rv, mlat + 2, o_gnt);
      end
      n_cmp++;
      if (o_rd !== prod(w) || o_re !== 1'b0 || o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_data t=%0d data=%h err=%b busy=%b want %h 0 0",
                 t, o_rd, o_re, o_busy, prod(w));
      end
      m_last = w;
    end
    req = '0;
    mlat = 36;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_mult_arbiter.md
# mont_mult_arbiter

Round-robin arbiter and sequencer that shares one bit-serial Montgomery multiplier (`mult`) among `NREQ` field-arithmetic requesters in the GFAU.
- Captures the winning requester's operands and pulses the multiplier start.
- Waits for the multiplier's done pulse, then returns the product to the owning requester.
- A watchdog reports a timeout if the multiplier hangs.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `SIZE`, default 32: operand width; matches `mult`.
- `TIMEOUT`, default 63: WAIT-state cycles before abort; must exceed multiplier latency (36).
- `i_clk`  in  1: clock, rising edge.
- `i_rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `req`  in  NREQ: per-requester request level; held until `gnt` bit seen.
- `opa`  in  NREQ*SIZE: operand A, requester k at bits [k*SIZE +: SIZE].
- `opb`  in  NREQ*SIZE: operand B, same packing.
- `gnt`  out  NREQ: one-hot, one-cycle pulse; operands of that requester have been captured.
- `rsp_valid`  out  NREQ: one-hot, one-cycle pulse; result for that requester on `rsp_data`.
- `rsp_data`  out  SIZE: product; valid only while a `rsp_valid` bit is 1.
- `rsp_err`  out  1: qualifies `rsp_valid`; 1 = timed out, `rsp_data` = 0.
- `busy`  out  1: 1 in every state except IDLE.
- `err_timeout`  out  1: sticky timeout flag, cleared only by reset.
- `mult_start`  out  1: one-cycle start pulse to `mult` (its `done_control`).
- `mult_in_0`, `mult_in_1`  out  SIZE: registered operands to `mult`.
- `mult_out`  in  SIZE: multiplier result.
- `mult_done`  in  1: multiplier one-cycle done pulse (`done_mult`).

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP. Encoding is free.
- **IDLE:**
  - If `req` is nonzero, pick the winner by round-robin: search starts at `last+1` (mod NREQ) and takes the first set bit.
  - Latch `opa`/`opb` slices into `mult_in_0`/`mult_in_1`, latch winner index into `owner`, go to ISSUE.
  - If `req` is zero, stay in IDLE.
- **ISSUE:** `gnt[owner]`=1 and `mult_start`=1 for this one cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT:**
  - If `mult_done`: register `mult_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Else if counter == TIMEOUT-1: set `rsp_data`=0, `rsp_err`=1, `err_timeout`=1, go to RESP.
  - Else: increment counter.
  - `mult_done` has priority if both conditions hit in the same cycle.
- **RESP:** `rsp_valid[owner]`=1 for one cycle. Set `last`=`owner`. Go to IDLE.
- **Ignored inputs:**
  - `mult_done` is ignored in IDLE, ISSUE and RESP, including a late done after a timeout.
  - `req` is sampled only in IDLE. A requester that keeps `req` high after its `rsp_valid` competes again, behind other pending requesters.
- **Operand hold:** `mult_in_0`/`mult_in_1` hold their value from capture until the next capture.
- **Counter width:** clog2(TIMEOUT+1) bits; never wraps.
- **Reduction:** no arithmetic on data. Reduction mod p stays inside `mult`.

## Timing
- **Reset values:**
  - All outputs 0 (`gnt`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `err_timeout`, `mult_start`, `mult_in_0`, `mult_in_1`).
  - State IDLE, `last`=NREQ-1 (requester 0 has first priority), counter 0.
- **Cycle sequence:**
  - Req seen in IDLE at cycle 0.
  - `gnt` and `mult_start` at cycle 1.
  - WAIT from cycle 2.
  - `mult_done` at cycle d gives `rsp_valid` at d+1 and IDLE at d+2.
  - Earliest next `gnt` is at d+3.
- **Latency:** `req` to `rsp_valid` = multiplier latency + 3 cycles. With the 36-cycle `mult`, that is 39 cycles.
- **Timeout:** the last WAIT cycle is cycle 1+TIMEOUT; `rsp_valid` with `rsp_err` follows the next cycle.
- **Reset mid-operation:** asynchronous return to IDLE with all reset values. No response is issued for the in-flight owner. `mult` shares `i_rst`.
- **Simultaneous requests:** exactly one grant per transaction. `gnt` and `rsp_valid` are never asserted in the same cycle.

## Test plan
- **Single request:** reset; `req`=4'b0001 with opa=0x00000003, opb=0x00000005; model `mult` with 36-cycle latency returning 0x12345678. Expect `gnt`=0001 at cycle 1, `mult_start` at cycle 1, `mult_in_0`=3 and `mult_in_1`=5, `rsp_valid`=0001 with `rsp_data`=0x12345678 at cycle 39, `busy` low at cycle 40.
- **All-request round-robin:** hold `req`=4'b1111 for 4 transactions. Expect grant order 0,1,2,3, then 0 again on the fifth; each `rsp_valid` bit matches the preceding `gnt` bit.
- **Fairness after service:** after requester 2 is served, assert `req`=4'b0101. Expect the next grant to go to requester 0 (search starts at 3), then requester 2.
- **Timeout:** multiplier model never pulses `mult_done`, TIMEOUT=63. Expect `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 64 cycles after `gnt`, and `err_timeout` staying 1. A late `mult_done` afterwards produces no response.
- **Spurious done:** pulse `mult_done` during IDLE and during the ISSUE cycle. Expect no `rsp_valid`; the real done later yields a normal response.
- **Reset mid-WAIT:** assert `i_rst` at cycle 20 of a transaction. All outputs go to 0 asynchronously (before the next edge). After release with `req`=0001, a fresh transaction completes with normal latency and requester 0 is granted first.
